// File: rtl/lr_pkt_arbiter.sv
// Packet-atomic 2:1 arbiter for the 134-bit LCM packet path (UM stream on A, beacon reports on B),
// plus the periodic report trigger and the missed-report / malformed-header counters.
module lr_pkt_arbiter #(
  parameter int unsigned B_BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_data_wr_i,
  input  logic [133:0] a_data_i,
  input  logic         a_data_valid_i,
  input  logic         a_data_valid_wr_i,
  output logic         a_ready_o,
  input  logic         b_data_wr_i,
  input  logic [133:0] b_data_i,
  input  logic         b_data_valid_i,
  input  logic         b_data_valid_wr_i,
  output logic         b_ready_o,
  output logic         out_data_wr_o,
  output logic [133:0] out_data_o,
  output logic         out_data_valid_o,
  output logic         out_data_valid_wr_o,
  input  logic [31:0]  cfg_report_period_i,
  output logic         rpt_req_o,
  output logic [15:0]  rpt_overrun_cnt_o,
  output logic [15:0]  hdr_err_cnt_o
);

  localparam logic [3:0]  BMAX = 4'(B_BURST_MAX);
  localparam logic [1:0]  HDR_FIRST = 2'b01;
  localparam logic [1:0]  HDR_MID   = 2'b11;
  localparam logic [1:0]  HDR_LAST  = 2'b10;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state_q;
  logic [3:0]    burst_cnt_q;
  logic          first_q;
  logic          out_data_wr_q;
  logic [133:0]  out_data_q;
  logic          out_data_valid_q;
  logic          out_data_valid_wr_q;
  logic [31:0]   period_cnt_q, period_cnt_d;
  logic          rpt_req_q;
  logic          rpt_pending_q;
  logic [15:0]   rpt_overrun_cnt_q;
  logic [15:0]   hdr_err_cnt_q;

  logic          xfer;
  logic [133:0]  x_data;
  logic          x_valid;
  logic          x_valid_wr;
  logic [1:0]    x_hdr;
  logic          hdr_bad;
  logic          rpt_fire;
  logic          rpt_clr;

  assign a_ready_o           = (state_q == GNT_A);
  assign b_ready_o           = (state_q == GNT_B);
  assign out_data_wr_o       = out_data_wr_q;
  assign out_data_o          = out_data_q;
  assign out_data_valid_o    = out_data_valid_q;
  assign out_data_valid_wr_o = out_data_valid_wr_q;
  assign rpt_req_o           = rpt_req_q;
  assign rpt_overrun_cnt_o   = rpt_overrun_cnt_q;
  assign hdr_err_cnt_o       = hdr_err_cnt_q;

  always_comb begin
    xfer       = (a_ready_o && a_data_wr_i) || (b_ready_o && b_data_wr_i);
    x_data     = b_ready_o ? b_data_i : a_data_i;
    x_valid    = b_ready_o ? b_data_valid_i : a_data_valid_i;
    x_valid_wr = b_ready_o ? b_data_valid_wr_i : a_data_valid_wr_i;
    x_hdr      = x_data[133:132];
    // A single-beat packet (10 on the first beat) is legal; 00 is never legal.
    hdr_bad    = xfer && ((x_hdr == 2'b00) ||
                          (first_q  && x_hdr == HDR_MID) ||
                          (!first_q && x_hdr == HDR_FIRST));
    rpt_clr    = b_ready_o && b_data_wr_i && (b_data_i[133:132] == HDR_FIRST);
    rpt_fire   = (cfg_report_period_i != 32'd0) &&
                 (period_cnt_q >= cfg_report_period_i - 32'd1);
    if (cfg_report_period_i == 32'd0 || rpt_fire) period_cnt_d = 32'd0;
    else                                          period_cnt_d = period_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      burst_cnt_q         <= 4'd0;
      first_q             <= 1'b0;
      out_data_wr_q       <= 1'b0;
      out_data_q          <= '0;
      out_data_valid_q    <= 1'b0;
      out_data_valid_wr_q <= 1'b0;
      period_cnt_q        <= 32'd0;
      rpt_req_q           <= 1'b0;
      rpt_pending_q       <= 1'b0;
      rpt_overrun_cnt_q   <= 16'd0;
      hdr_err_cnt_q       <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (b_data_wr_i && (burst_cnt_q < BMAX || !a_data_wr_i)) begin
            state_q     <= GNT_B;
            first_q     <= 1'b1;
            burst_cnt_q <= (burst_cnt_q < BMAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
          end else if (a_data_wr_i) begin
            state_q     <= GNT_A;
            first_q     <= 1'b1;
            burst_cnt_q <= 4'd0;
          end
        end
        GNT_A, GNT_B: begin
          if (xfer) begin
            first_q <= 1'b0;
            if (x_hdr == HDR_LAST) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      out_data_wr_q       <= xfer;
      out_data_q          <= xfer ? x_data : '0;
      out_data_valid_q    <= xfer && x_valid;
      out_data_valid_wr_q <= xfer && x_valid_wr;

      if (hdr_bad && hdr_err_cnt_q != CNT_MAX) hdr_err_cnt_q <= hdr_err_cnt_q + 16'd1;

      period_cnt_q <= period_cnt_d;
      rpt_req_q    <= rpt_fire;

      // A trigger landing together with the clearing B header wins and is not an overrun.
      if (rpt_req_q) begin
        rpt_pending_q <= 1'b1;
        if (rpt_pending_q && !rpt_clr && rpt_overrun_cnt_q != CNT_MAX)
          rpt_overrun_cnt_q <= rpt_overrun_cnt_q + 16'd1;
      end else if (rpt_clr) begin
        rpt_pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lr_pkt_arbiter.sv
// Directed bench for lr_pkt_arbiter: latency/format, arbitration order, burst limit,
// header-error counting, report timer/overrun and asynchronous reset.
module tb_lr_pkt_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_data_wr, a_data_valid, a_data_valid_wr, a_ready;
  logic [133:0] a_data;
  logic         b_data_wr, b_data_valid, b_data_valid_wr, b_ready;
  logic [133:0] b_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic [133:0] out_data;
  logic [31:0]  cfg_report_period;
  logic         rpt_req;
  logic [15:0]  rpt_overrun_cnt, hdr_err_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int nbeats_out = 0;
  int first_cyc [2];
  int last_cyc [2];
  logic [8:0]   ids [$];
  logic [133:0] last_out;

  lr_pkt_arbiter #(.B_BURST_MAX(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .a_data_wr_i         (a_data_wr),
    .a_data_i            (a_data),
    .a_data_valid_i      (a_data_valid),
    .a_data_valid_wr_i   (a_data_valid_wr),
    .a_ready_o           (a_ready),
    .b_data_wr_i         (b_data_wr),
    .b_data_i            (b_data),
    .b_data_valid_i      (b_data_valid),
    .b_data_valid_wr_i   (b_data_valid_wr),
    .b_ready_o           (b_ready),
    .out_data_wr_o       (out_data_wr),
    .out_data_o          (out_data),
    .out_data_valid_o    (out_data_valid),
    .out_data_valid_wr_o (out_data_valid_wr),
    .cfg_report_period_i (cfg_report_period),
    .rpt_req_o           (rpt_req),
    .rpt_overrun_cnt_o   (rpt_overrun_cnt),
    .hdr_err_cnt_o       (hdr_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs packet ids in completion order and beat timing per port.
  always @(negedge clk) begin
    if (out_data_wr) begin
      nbeats_out = nbeats_out + 1;
      last_out   = out_data;
      if (out_data[133:132] == 2'b01) first_cyc[out_data[16]] = cyc;
      if (out_data[133:132] == 2'b10) begin
        last_cyc[out_data[16]] = cyc;
        ids.push_back({out_data[16], out_data[15:8]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [133:0] mkbeat(input logic [1:0] h, input bit port,
                                          input logic [7:0] id, input int idx);
    logic [133:0] d;
    d = '0;
    d[133:132] = h;
    d[131:100] = {24'hC0FFEE, id};
    d[16]      = port;
    d[15:8]    = id;
    d[3:0]     = idx[3:0];
    return d;
  endfunction

  task automatic drive(input bit port, input logic wr, input logic [133:0] d,
                       input logic v, input logic vw);
    if (port) begin
      b_data_wr = wr; b_data = d; b_data_valid = v; b_data_valid_wr = vw;
    end else begin
      a_data_wr = wr; a_data = d; a_data_valid = v; a_data_valid_wr = vw;
    end
  endtask

  // hdrs holds the 2-bit header of beat i at [2*i +: 2]; called at a negedge.
  task automatic send_pkt(input bit port, input logic [7:0] id, input int nb,
                          input logic [15:0] hdrs);
    int n;
    logic last;
    for (int i = 0; i < nb; i++) begin
      last = (i == nb - 1);
      drive(port, 1'b1, mkbeat(hdrs[2*i +: 2], port, id, i), last, last);
      n = 0;
      while (!(port ? b_ready : a_ready) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) chk("ready_timeout", 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(port, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_pulse(output int c);
    int n;
    n = 0;
    while (!rpt_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rpt_req) chk("pulse_timeout", 1'b0, 1'b1);
    c = cyc;
  endtask

  initial begin
    logic [133:0] b0, b1, b2;
    logic [8:0]   exp_id, got_id;
    int           n0, p1, p2, p3, n;

    rst_n = 1'b0;
    cfg_report_period = 32'd0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_out_wr", out_data_wr, 1'b0);
    chk("rst_rpt_req", rpt_req, 1'b0);
    chk("rst_overrun", rpt_overrun_cnt, 16'd0);
    chk("rst_hdr_err", hdr_err_cnt, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // A-only 3-beat packet: grant after 1 cycle, beats out with latency 1.
    b0 = mkbeat(2'b01, 1'b0, 8'd1, 0);
    b1 = mkbeat(2'b11, 1'b0, 8'd1, 1);
    b2 = mkbeat(2'b10, 1'b0, 8'd1, 2);
    drive(1'b0, 1'b1, b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_a_ready", a_ready, 1'b1);
    chk("t1_out_idle", out_data_wr, 1'b0);
    @(negedge clk);
    chk("t1_beat0_wr", out_data_wr, 1'b1);
    chk("t1_beat0", out_data, b0);
    chk("t1_beat0_valid", out_data_valid, 1'b0);
    drive(1'b0, 1'b1, b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_beat1", out_data, b1);
    drive(1'b0, 1'b1, b2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_beat2", out_data, b2);
    chk("t1_beat2_valid", out_data_valid, 1'b1);
    chk("t1_beat2_valid_wr", out_data_valid_wr, 1'b1);
    chk("t1_idle_after_last", a_ready, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_out_wr_low", out_data_wr, 1'b0);
    chk("t1_out_data_zero", out_data, '0);

    // A and B together with burst_cnt=0: B first, one bubble, then A.
    ids.delete();
    fork
      send_pkt(1'b1, 8'd1, 2, 16'b1001);
      send_pkt(1'b0, 8'd1, 2, 16'b1001);
    join
    repeat (3) @(negedge clk);
    chk("t2_npkts", ids.size(), 2);
    got_id = (ids.size() > 0) ? ids[0] : 9'h1FF;
    chk("t2_first_is_b", got_id, {1'b1, 8'd1});
    got_id = (ids.size() > 1) ? ids[1] : 9'h1FF;
    chk("t2_second_is_a", got_id, {1'b0, 8'd1});
    chk("t2_bubble", first_cyc[0] - last_cyc[1], 2);

    // Six back-to-back B packets with A waiting, burst limit 4.
    ids.delete();
    fork
      begin
        for (int i = 1; i <= 6; i++) send_pkt(1'b1, 8'(i), 2, 16'b1001);
      end
      send_pkt(1'b0, 8'd2, 2, 16'b1001);
    join
    repeat (3) @(negedge clk);
    chk("t3_npkts", ids.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < 4)       exp_id = {1'b1, 8'(i + 1)};
      else if (i == 4) exp_id = {1'b0, 8'd2};
      else             exp_id = {1'b1, 8'(i)};
      got_id = (i < ids.size()) ? ids[i] : 9'h1FF;
      chk($sformatf("t3_order%0d", i), got_id, exp_id);
    end

    // Header errors: first beat 11, then a mid-packet 01; all beats forwarded.
    chk("t4_hdr_err_before", hdr_err_cnt, 16'd0);
    n0 = nbeats_out;
    send_pkt(1'b0, 8'd3, 3, 16'b100111);
    repeat (2) @(negedge clk);
    chk("t4_hdr_err", hdr_err_cnt, 16'd2);
    chk("t4_beats_fwd", nbeats_out - n0, 3);
    chk("t4_last_beat", last_out, mkbeat(2'b10, 1'b0, 8'd3, 2));

    // Report timer, no B traffic: overruns counted from the 2nd pulse.
    cfg_report_period = 32'd10;
    wait_pulse(p1);
    @(negedge clk);
    chk("t5_pulse_width", rpt_req, 1'b0);
    chk("t5_overrun_p1", rpt_overrun_cnt, 16'd0);
    wait_pulse(p2);
    chk("t5_period12", p2 - p1, 10);
    @(negedge clk);
    chk("t5_overrun_p2", rpt_overrun_cnt, 16'd1);
    wait_pulse(p3);
    chk("t5_period23", p3 - p2, 10);
    @(negedge clk);
    chk("t5_overrun_p3", rpt_overrun_cnt, 16'd2);

    // Asynchronous reset in the middle of an A packet.
    drive(1'b0, 1'b1, mkbeat(2'b01, 1'b0, 8'd4, 0), 1'b0, 1'b0);
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t6_mid_pkt_out", out_data_wr, 1'b1);
    drive(1'b0, 1'b1, mkbeat(2'b11, 1'b0, 8'd4, 1), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_a_ready", a_ready, 1'b0);
    chk("t6_async_out_wr", out_data_wr, 1'b0);
    chk("t6_async_out_data", out_data, '0);
    chk("t6_async_overrun", rpt_overrun_cnt, 16'd0);
    chk("t6_async_hdr_err", hdr_err_cnt, 16'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_idle_a", a_ready, 1'b0);
    chk("t6_idle_b", b_ready, 1'b0);
    chk("t6_hdr_err_zero", hdr_err_cnt, 16'd0);

    // Report timer with a B packet after each pulse: no overruns.
    for (int k = 0; k < 4; k++) begin
      wait_pulse(p1);
      @(negedge clk);
      chk($sformatf("t7_overrun_p%0d", k), rpt_overrun_cnt, 16'd0);
      send_pkt(1'b1, 8'(20 + k), 3, 16'b101101);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
